npu: RTL and testbench
======================

Name: npu

Overview:
- Small fixed-point neural processing unit: one neuron evaluated repeatedly as a multiply-accumulate engine.
- Fed by three FIFOs: a 26-bit configuration FIFO (weights, layer setup), a 32-bit input FIFO (activations) and a 32-bit output FIFO (results).
- Sits as a memory-mapped accelerator beside the host core; the host pushes config and inputs and pops results.

Parameters:
- FIFO_DEPTH, 16, entries in each of the three FIFOs (power of two).
- MAX_INPUTS, 16, size of the weight memory and maximum neuron fan-in.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  reset; synchronous, active-high.
- npu_input_data  input  32  signed Q16.16 activation to push.
- npu_input_fifo_write_enable  input  1  push npu_input_data.
- npu_config_data  input  26  config word to push.
- npu_config_fifo_write_enable  input  1  push npu_config_data.
- npu_output_fifo_read_enable  input  1  pop the output FIFO head.
- npu_output_data  output  32  output FIFO head, first-word-fall-through.
- npu_output_fifo_empty  output  1  output FIFO holds 0 entries.
- npu_input_fifo_full  output  1  input FIFO holds FIFO_DEPTH entries.
- npu_config_fifo_full  output  1  config FIFO holds FIFO_DEPTH entries.

Behaviour:
- Reset:
  - All FIFOs flushed; npu_output_fifo_empty=1, both full flags=0, npu_output_data=0.
  - Weights=0, configured=0, N=0, bias=0, relu=0, state IDLE.
  - Reset mid-computation aborts the computation; no partial result is pushed.
- FIFO rules:
  - A push is accepted only when the FIFO is not full in that cycle; otherwise the data is silently dropped.
  - A pop on an empty FIFO is ignored and npu_output_data holds its value.
  - A simultaneous push and pop on a non-full FIFO both take effect and the count is unchanged.
  - Flags are registered and reflect the count after the edge.
  - npu_output_data shows the head entry combinationally; it is 0 while empty.
- Config word: op=[25:24].
  - 00 NOP: discarded.
  - 01 WEIGHT: weight[[19:16] mod MAX_INPUTS] = [15:0], signed Q8.8. Bits [23:20] are ignored.
  - 10 LAYER: N=[4:0], relu=[7], bias=[23:8] (signed Q8.8). N in 1..MAX_INPUTS sets configured=1; any other N clears configured. Bits [6:5] are ignored.
  - 11: discarded.
- FSM states: IDLE, ACC, FINISH, WRITE.
  - IDLE: if the config FIFO is non-empty, pop and apply one word per cycle (config has priority). Else if configured and the input FIFO is non-empty, clear acc, set k=0 and go to ACC.
  - ACC: each cycle the input FIFO is non-empty, pop x and do acc += x*weight[k] (signed 32x16 -> 48-bit product, 52-bit accumulator), then k++. Stall while the input FIFO is empty. After the N-th pop go to FINISH.
  - FINISH:
    - r = (acc >>> 8) + (sign_ext(bias) << 8).
    - Saturate r to the signed 32-bit range [0x80000000, 0x7FFFFFFF].
    - If relu=1 and r<0, then r=0.
    - Go to WRITE.
  - WRITE: push r when the output FIFO is not full (stall while full), then go to IDLE.
  - Config is never consumed outside IDLE, so a result always uses the weights, bias and N in force at ACC entry.
- Latency: last input pop to result visible at the output head is 2 cycles (FINISH, WRITE) plus 1 for the registered push. Minimum throughput is one result per N+3 cycles.

Test Plan:
- Reset 5 cycles, then push config 0,1,2,... every cycle for 90 cycles (all NOP) -> npu_config_fifo_full stays 0, npu_output_fifo_empty stays 1, npu_output_data=0.
- WEIGHT idx0=0x0100, WEIGHT idx1=0x0200, LAYER N=2 bias=0 relu=0; push inputs 0x00010000 and 0x00030000 -> one result 0x00070000. Empty deasserts; after one read, empty reasserts.
- WEIGHT idx0=0xFF00, LAYER N=1 relu=0; input 0x00050000 -> 0xFFFB0000. Repeat with relu=1 -> 0x00000000.
- WEIGHT idx0=0x0100, LAYER N=1 bias=0x0080; input 0x00010000 -> 0x00018000. Input 0x7FFFFFFF with weight 0x7FFF -> 0x7FFFFFFF (saturation).
- No LAYER after reset: push 17 inputs -> npu_input_fifo_full=1 after the 16th write, the 17th is dropped, and no output is produced.
- Fill the output FIFO (16 results, N=1) without reading, then push another input -> engine stalls in WRITE. After one read, the 17th result is pushed and the FIFO order is preserved.

Source files
------------

// File: rtl/npu.sv
// Single-neuron fixed-point MAC engine fed by config/input FIFOs and draining into an output FIFO.
// Q16.16 activations times Q8.8 weights, Q8.8 bias, optional ReLU, saturated to signed 32 bits.

module npu_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_next;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_comb begin
      count_next = count;
      if (do_push && !do_pop)
         count_next = count + (AW+1)'(1);
      else if (!do_push && do_pop)
         count_next = count - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         full  <= (count_next == (AW+1)'(DEPTH));
         empty <= (count_next == '0);
      end
   end
endmodule

module npu #(
   parameter int FIFO_DEPTH = 16,
   parameter int MAX_INPUTS = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] npu_input_data,
   input  logic        npu_input_fifo_write_enable,
   input  logic [25:0] npu_config_data,
   input  logic        npu_config_fifo_write_enable,
   input  logic        npu_output_fifo_read_enable,
   output logic [31:0] npu_output_data,
   output logic        npu_output_fifo_empty,
   output logic        npu_input_fifo_full,
   output logic        npu_config_fifo_full
);
   localparam int IW = (MAX_INPUTS > 1) ? $clog2(MAX_INPUTS) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACC    = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;
   localparam logic [1:0] S_WRITE  = 2'd3;

   logic [1:0]         state;
   logic signed [15:0] weight [MAX_INPUTS];
   logic               configured;
   logic [4:0]         n;
   logic signed [15:0] bias;
   logic               relu;
   logic signed [51:0] acc;
   logic [4:0]         k;
   logic [31:0]        result;

   logic [25:0] cfg_head;
   logic        cfg_empty;
   logic        cfg_pop;
   logic [31:0] in_head;
   logic        in_empty;
   logic        in_pop;
   logic        out_full;
   logic        out_push;

   npu_fifo #(.W(26), .DEPTH(FIFO_DEPTH)) u_cfg_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (npu_config_fifo_write_enable),
      .push_data (npu_config_data),
      .pop       (cfg_pop),
      .head      (cfg_head),
      .full      (npu_config_fifo_full),
      .empty     (cfg_empty)
   );

   npu_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_in_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (npu_input_fifo_write_enable),
      .push_data (npu_input_data),
      .pop       (in_pop),
      .head      (in_head),
      .full      (npu_input_fifo_full),
      .empty     (in_empty)
   );

   npu_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_out_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (out_push),
      .push_data (result),
      .pop       (npu_output_fifo_read_enable),
      .head      (npu_output_data),
      .full      (out_full),
      .empty     (npu_output_fifo_empty)
   );

   assign cfg_pop  = (state == S_IDLE) && !cfg_empty;
   assign in_pop   = (state == S_ACC) && !in_empty;
   assign out_push = (state == S_WRITE) && !out_full;

   // Config field decode
   logic [1:0]    cfg_op;
   logic [IW-1:0] widx;
   logic          n_valid;
   logic          cfg_unused;

   assign cfg_op     = cfg_head[25:24];
   assign widx       = IW'(32'(cfg_head[19:16]) % MAX_INPUTS);
   assign n_valid    = (cfg_head[4:0] != 5'd0) && (32'(cfg_head[4:0]) <= MAX_INPUTS);
   assign cfg_unused = ^cfg_head[6:5];

   // Multiply-accumulate datapath
   logic signed [47:0] x_ext;
   logic signed [47:0] w_ext;
   logic signed [47:0] prod;
   logic signed [51:0] acc_next;
   logic signed [15:0] w_sel;

   assign w_sel    = weight[k[IW-1:0]];
   assign x_ext    = $signed({{16{in_head[31]}}, in_head});
   assign w_ext    = $signed({{32{w_sel[15]}}, w_sel});
   assign prod     = x_ext * w_ext;
   assign acc_next = acc + $signed({{4{prod[47]}}, prod});

   // Rescale to Q16.16, add bias, saturate, optional ReLU
   logic signed [52:0] sum;
   logic [31:0]        r_final;

   always_comb begin
      sum = $signed({{9{acc[51]}}, acc[51:8]}) + $signed({{29{bias[15]}}, bias, 8'b0});
      if (sum[52:31] == {22{sum[52]}})
         r_final = sum[31:0];
      else
         r_final = sum[52] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      if (relu && r_final[31])
         r_final = '0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         configured <= 1'b0;
         n          <= '0;
         bias       <= '0;
         relu       <= 1'b0;
         acc        <= '0;
         k          <= '0;
         result     <= '0;
         for (int i = 0; i < MAX_INPUTS; i++)
            weight[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!cfg_empty) begin
                  if (cfg_op == 2'b01) begin
                     weight[widx] <= $signed(cfg_head[15:0]);
                  end else if (cfg_op == 2'b10) begin
                     n          <= cfg_head[4:0];
                     relu       <= cfg_head[7];
                     bias       <= $signed(cfg_head[23:8]);
                     configured <= n_valid;
                  end
               end else if (configured && !in_empty) begin
                  acc   <= '0;
                  k     <= '0;
                  state <= S_ACC;
               end
            end
            S_ACC: begin
               if (!in_empty) begin
                  acc <= acc_next;
                  k   <= k + 5'd1;
                  if (k + 5'd1 == n)
                     state <= S_FINISH;
               end
            end
            S_FINISH: begin
               result <= r_final;
               state  <= S_WRITE;
            end
            default: begin
               if (!out_full)
                  state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_npu.sv
// Randomized and directed bench for npu against an arithmetic reference model.
module tb_npu;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] npu_input_data = '0;
   logic        npu_input_fifo_write_enable = 1'b0;
   logic [25:0] npu_config_data = '0;
   logic        npu_config_fifo_write_enable = 1'b0;
   logic        npu_output_fifo_read_enable = 1'b0;
   logic [31:0] npu_output_data;
   logic        npu_output_fifo_empty;
   logic        npu_input_fifo_full;
   logic        npu_config_fifo_full;

   npu #(.FIFO_DEPTH(16), .MAX_INPUTS(16)) dut (
      .CLK                          (CLK),
      .RST                          (RST),
      .npu_input_data               (npu_input_data),
      .npu_input_fifo_write_enable  (npu_input_fifo_write_enable),
      .npu_config_data              (npu_config_data),
      .npu_config_fifo_write_enable (npu_config_fifo_write_enable),
      .npu_output_fifo_read_enable  (npu_output_fifo_read_enable),
      .npu_output_data              (npu_output_data),
      .npu_output_fifo_empty        (npu_output_fifo_empty),
      .npu_input_fifo_full          (npu_input_fifo_full),
      .npu_config_fifo_full         (npu_config_fifo_full)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   shortint     mw [16];
   int          mn;
   shortint     mbias;
   bit          mrelu;
   bit          mcfg;
   int          pend [$];
   logic [31:0] expq [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_cycles(input int c);
      repeat (c) tick();
   endtask

   function automatic logic [25:0] wcfg(input int idx, input logic [15:0] val);
      logic [3:0] i4;
      i4 = 4'(idx);
      return {2'b01, 4'b0000, i4, val};
   endfunction

   function automatic logic [25:0] lcfg(input int nn, input logic [15:0] b, input bit r);
      logic [4:0] n5;
      n5 = 5'(nn);
      return {2'b10, b, r, 2'b00, n5};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) mw[i] = 0;
      mn = 0; mbias = 0; mrelu = 0; mcfg = 0;
      pend.delete();
      expq.delete();
   endfunction

   function automatic void model_cfg(input logic [25:0] c);
      if (c[25:24] == 2'b01) begin
         mw[int'(c[19:16]) % 16] = shortint'(c[15:0]);
      end else if (c[25:24] == 2'b10) begin
         mn    = int'(c[4:0]);
         mrelu = c[7];
         mbias = shortint'(c[23:8]);
         mcfg  = (mn >= 1) && (mn <= 16);
      end
   endfunction

   function automatic void model_input(input int x);
      longint a;
      longint r;
      if (!mcfg) return;
      pend.push_back(x);
      if (pend.size() == mn) begin
         a = 0;
         for (int i = 0; i < mn; i++) a += longint'(pend[i]) * longint'(mw[i]);
         r = (a >>> 8) + longint'(mbias) * 256;
         if (r > 64'sd2147483647) r = 64'sd2147483647;
         if (r < -64'sd2147483648) r = -64'sd2147483648;
         if (mrelu && r < 0) r = 0;
         expq.push_back(r[31:0]);
         pend.delete();
      end
   endfunction

   task automatic do_reset();
      RST = 1'b1;
      npu_input_fifo_write_enable = 1'b0;
      npu_config_fifo_write_enable = 1'b0;
      npu_output_fifo_read_enable = 1'b0;
      wait_cycles(5);
      RST = 1'b0;
      model_reset();
   endtask

   task automatic push_cfg(input logic [25:0] c);
      npu_config_data = c;
      npu_config_fifo_write_enable = 1'b1;
      tick();
      npu_config_fifo_write_enable = 1'b0;
   endtask

   task automatic push_in(input logic [31:0] x);
      npu_input_data = x;
      npu_input_fifo_write_enable = 1'b1;
      tick();
      npu_input_fifo_write_enable = 1'b0;
   endtask

   task automatic cfg(input logic [25:0] c);
      push_cfg(c);
      model_cfg(c);
   endtask

   task automatic inp(input int x);
      push_in(x);
      model_input(x);
   endtask

   task automatic pop_check(input string tag, input logic [31:0] exp);
      check({tag, "_empty"}, {31'b0, npu_output_fifo_empty}, 32'd0);
      check(tag, npu_output_data, exp);
      npu_output_fifo_read_enable = 1'b1;
      tick();
      npu_output_fifo_read_enable = 1'b0;
   endtask

   task automatic drain(input string tag);
      logic [31:0] e;
      while (expq.size() > 0) begin
         e = expq.pop_front();
         pop_check(tag, e);
      end
      check({tag, "_drained"}, {31'b0, npu_output_fifo_empty}, 32'd1);
   endtask

   initial begin
      int n;
      int b;
      int x;

      do_reset();
      check("rst_out_empty", {31'b0, npu_output_fifo_empty}, 32'd1);
      check("rst_in_full", {31'b0, npu_input_fifo_full}, 32'd0);
      check("rst_cfg_full", {31'b0, npu_config_fifo_full}, 32'd0);
      check("rst_data", npu_output_data, 32'd0);

      for (int i = 0; i < 90; i++) begin
         push_cfg(26'(i));
         check("nop_cfg_full", {31'b0, npu_config_fifo_full}, 32'd0);
         check("nop_out_empty", {31'b0, npu_output_fifo_empty}, 32'd1);
         check("nop_data", npu_output_data, 32'd0);
      end

      // basic two-input dot product
      push_cfg(wcfg(0, 16'h0100));
      push_cfg(wcfg(1, 16'h0200));
      push_cfg(lcfg(2, 16'h0000, 1'b0));
      wait_cycles(5);
      push_in(32'h0001_0000);
      push_in(32'h0003_0000);
      wait_cycles(10);
      pop_check("dot2", 32'h0007_0000);
      check("dot2_empty_after", {31'b0, npu_output_fifo_empty}, 32'd1);

      // negative weight, then ReLU clamps it
      push_cfg(wcfg(0, 16'hFF00));
      push_cfg(lcfg(1, 16'h0000, 1'b0));
      wait_cycles(5);
      push_in(32'h0005_0000);
      wait_cycles(10);
      pop_check("neg", 32'hFFFB_0000);
      push_cfg(lcfg(1, 16'h0000, 1'b1));
      wait_cycles(5);
      push_in(32'h0005_0000);
      wait_cycles(10);
      pop_check("relu", 32'h0000_0000);

      // bias and saturation in both directions
      push_cfg(wcfg(0, 16'h0100));
      push_cfg(lcfg(1, 16'h0080, 1'b0));
      wait_cycles(5);
      push_in(32'h0001_0000);
      wait_cycles(10);
      pop_check("bias", 32'h0001_8000);
      push_cfg(wcfg(0, 16'h7FFF));
      wait_cycles(5);
      push_in(32'h7FFF_FFFF);
      wait_cycles(10);
      pop_check("sat_pos", 32'h7FFF_FFFF);
      push_cfg(wcfg(0, 16'h8000));
      wait_cycles(5);
      push_in(32'h7FFF_FFFF);
      wait_cycles(10);
      pop_check("sat_neg", 32'h8000_0000);

      // unconfigured engine: input FIFO fills, 17th write dropped
      do_reset();
      push_cfg(wcfg(0, 16'h0100));
      for (int i = 1; i <= 17; i++) begin
         push_in(32'(i) << 16);
         check("in_full", {31'b0, npu_input_fifo_full}, (i >= 16) ? 32'd1 : 32'd0);
      end
      wait_cycles(10);
      check("unconf_no_out", {31'b0, npu_output_fifo_empty}, 32'd1);

      // now configure: 16 results fill the output FIFO, one more stalls in WRITE
      push_cfg(lcfg(1, 16'h0000, 1'b0));
      wait_cycles(100);
      push_in(32'h0064_0000);
      wait_cycles(20);
      check("stall_in_full", {31'b0, npu_input_fifo_full}, 32'd0);
      pop_check("ofull_0", 32'h0001_0000);
      wait_cycles(10);
      for (int i = 2; i <= 16; i++) pop_check("ofull_seq", 32'(i) << 16);
      pop_check("ofull_last", 32'h0064_0000);
      check("ofull_empty", {31'b0, npu_output_fifo_empty}, 32'd1);

      // reset mid-computation aborts with no result
      do_reset();
      push_cfg(wcfg(0, 16'h0100));
      push_cfg(lcfg(4, 16'h0000, 1'b0));
      wait_cycles(5);
      push_in(32'h0001_0000);
      push_in(32'h0002_0000);
      wait_cycles(2);
      do_reset();
      wait_cycles(20);
      check("abort_empty", {31'b0, npu_output_fifo_empty}, 32'd1);
      check("abort_data", npu_output_data, 32'd0);

      // randomized layers against the reference model
      do_reset();
      for (int round = 0; round < 24; round++) begin
         n = $urandom_range(1, 16);
         for (int i = 0; i < n; i++)
            cfg({2'b01, 4'($urandom), 4'(i), 16'($urandom)});
         if ($urandom_range(0, 2) == 0) cfg({2'b11, 24'($urandom)});
         if ($urandom_range(0, 2) == 0) cfg({2'b00, 24'($urandom)});
         if ($urandom_range(0, 3) == 0) cfg({2'b10, 16'($urandom), 3'($urandom), 5'(17 + $urandom_range(0, 14))});
         cfg({2'b10, 16'($urandom), 1'($urandom), 2'($urandom), 5'(n)});
         wait_cycles(25);
         b = $urandom_range(1, 2);
         for (int j = 0; j < b * n; j++) begin
            if ($urandom_range(0, 3) == 0) x = int'($urandom);
            else x = int'($urandom_range(0, 32'h0008_0000)) - 32'sh0004_0000;
            inp(x);
         end
         wait_cycles(b * (n + 3) + 20);
         drain("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
